// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM encoding, access-size codes and sizing helper for mem_arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_ABORT} state_t;

    localparam logic [2:0] SZ_B = 3'b000;
    localparam logic [2:0] SZ_H = 3'b001;
    localparam logic [2:0] SZ_W = 3'b010;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_rr_picker.sv
// rr_picker: first eligible channel at or after base (wrapping), as one-hot and index.
// Tie base to zero for plain lowest-index priority.
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH = 2,
    localparam int IW = idx_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] elig,
    input  logic [IW-1:0]     base,
    output logic [NUM_CH-1:0] grant,
    output logic [IW-1:0]     idx,
    output logic              any
);

    logic [NUM_CH-1:0] rot;
    logic [IW:0]       s;

    // rot[k] is channel (base + k) mod NUM_CH
    assign rot = NUM_CH'({elig, elig} >> base);

    always_comb begin
        grant = '0;
        idx = '0;
        any = 1'b0;
        s = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (rot[k]) begin
                s = {1'b0, base} + (IW + 1)'(k);
                idx = (s >= (IW + 1)'(NUM_CH)) ? IW'(s - (IW + 1)'(NUM_CH)) : s[IW-1:0];
                any = 1'b1;
            end
        end
        grant[idx] = any;
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: N-channel fixed/round-robin arbiter in front of the byte-serial memory controller.
// Define MEM_ARB_PERF_EN to add per-channel completion counters and an abort counter.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int                NUM_CH     = 2,
    parameter int                AW         = 32,
    parameter int                DW         = 32,
    parameter bit                RR_EN      = 1'b1,
    parameter logic [NUM_CH-1:0] FLUSH_MASK = {NUM_CH{1'b1}}
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 rdy_in,
    input  logic                 flush_in,
    input  logic [NUM_CH-1:0]    req_valid,
    input  logic [NUM_CH-1:0]    req_wr,
    input  logic [3*NUM_CH-1:0]  req_size,
    input  logic [AW*NUM_CH-1:0] req_addr,
    input  logic [DW*NUM_CH-1:0] req_wdata,
    output logic [NUM_CH-1:0]    req_ready,
    output logic [DW-1:0]        req_rdata,
    output logic                 mc_valid,
    output logic                 mc_wr,
    output logic [2:0]           mc_len,
    output logic [AW-1:0]        mc_addr,
    output logic [DW-1:0]        mc_data,
    output logic                 mc_abort,
    input  logic                 mc_ready,
    input  logic [DW-1:0]        mc_res,
    output logic                 busy_out
`ifdef MEM_ARB_PERF_EN
   ,output logic [32*NUM_CH-1:0] perf_grants,
    output logic [31:0]          perf_aborts
`endif
);

    localparam int IW = idx_w(NUM_CH);

    state_t            state;
    logic [IW-1:0]     grant;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     base;
    logic [IW-1:0]     pick_idx;
    logic [NUM_CH-1:0] grant_oh;
    logic [NUM_CH-1:0] pick_oh;
    logic [NUM_CH-1:0] elig;
    logic              pick_any;
    logic              abort_cond;
    logic              done;

    assign elig = req_valid & ~({NUM_CH{flush_in}} & FLUSH_MASK);
    assign base = RR_EN ? rr_ptr : '0;

    rr_picker #(.NUM_CH(NUM_CH)) u_pick (
        .elig (elig),
        .base (base),
        .grant(pick_oh),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // a flush of a flushable grant wins over a same-cycle completion
    assign abort_cond = flush_in & FLUSH_MASK[grant];
    assign done       = rdy_in & (state == ST_BUSY) & mc_ready & ~abort_cond;
    assign req_ready  = done ? grant_oh : '0;
    assign req_rdata  = done ? mc_res : '0;
    assign busy_out   = state != ST_IDLE;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state    <= ST_IDLE;
            grant    <= '0;
            grant_oh <= '0;
            rr_ptr   <= '0;
            mc_valid <= 1'b0;
            mc_wr    <= 1'b0;
            mc_len   <= '0;
            mc_addr  <= '0;
            mc_data  <= '0;
            mc_abort <= 1'b0;
        end else if (rdy_in) begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        state    <= ST_BUSY;
                        grant    <= pick_idx;
                        grant_oh <= pick_oh;
                        mc_valid <= 1'b1;
                        mc_wr    <= req_wr[pick_idx];
                        mc_len   <= req_size[pick_idx*3 +: 3];
                        mc_addr  <= req_addr[pick_idx*AW +: AW];
                        mc_data  <= req_wdata[pick_idx*DW +: DW];
                    end
                end
                ST_BUSY: begin
                    if (abort_cond) begin
                        state    <= ST_ABORT;
                        mc_valid <= 1'b0;
                        mc_abort <= 1'b1;
                    end else if (mc_ready) begin
                        state    <= ST_IDLE;
                        mc_valid <= 1'b0;
                        rr_ptr   <= (grant == IW'(NUM_CH - 1)) ? '0 : grant + 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    mc_abort <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            perf_grants <= '0;
            perf_aborts <= '0;
        end else if (rdy_in) begin
            if (state == ST_BUSY && abort_cond)
                perf_aborts <= perf_aborts + 32'd1;
            for (int i = 0; i < NUM_CH; i++)
                if (done && grant_oh[i])
                    perf_grants[32*i +: 32] <= perf_grants[32*i +: 32] + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench; a round-robin instance (ch0 flushable only) and a fixed-priority instance.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        int          ch;
        logic        wr;
        logic [2:0]  size;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int          lat;
    } exp_t;

    logic clk_in = 1'b0;
    logic rst_n_in, rdy_in, flush_in, mc_ready, use_fp;
    logic [N-1:0]    req_valid, req_wr;
    logic [3*N-1:0]  req_size;
    logic [AW*N-1:0] req_addr;
    logic [DW*N-1:0] req_wdata;
    logic [DW-1:0]   mc_res;

    logic [N-1:0]  req_ready, fp_req_ready, o_ready;
    logic [DW-1:0] req_rdata, fp_req_rdata, o_rdata;
    logic          mc_valid, fp_mc_valid, o_valid;
    logic          mc_wr, fp_mc_wr, o_wr;
    logic [2:0]    mc_len, fp_mc_len, o_len;
    logic [AW-1:0] mc_addr, fp_mc_addr, o_addr;
    logic [DW-1:0] mc_data, fp_mc_data, o_data;
    logic          mc_abort, fp_mc_abort, busy_out, fp_busy_out;
`ifdef MEM_ARB_PERF_EN
    logic [32*N-1:0] perf_grants, fp_perf_grants;
    logic [31:0]     perf_aborts, fp_perf_aborts;
`endif

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk_in = ~clk_in;

    mem_arbiter #(.NUM_CH(N), .AW(AW), .DW(DW), .RR_EN(1'b1), .FLUSH_MASK(2'b01)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .req_valid(req_valid), .req_wr(req_wr), .req_size(req_size), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready), .req_rdata(req_rdata),
        .mc_valid(mc_valid), .mc_wr(mc_wr), .mc_len(mc_len), .mc_addr(mc_addr),
        .mc_data(mc_data), .mc_abort(mc_abort), .mc_ready(mc_ready), .mc_res(mc_res),
        .busy_out(busy_out)
`ifdef MEM_ARB_PERF_EN
       ,.perf_grants(perf_grants), .perf_aborts(perf_aborts)
`endif
    );

    mem_arbiter #(.NUM_CH(N), .AW(AW), .DW(DW), .RR_EN(1'b0)) dut_fp (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .req_valid(req_valid), .req_wr(req_wr), .req_size(req_size), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(fp_req_ready), .req_rdata(fp_req_rdata),
        .mc_valid(fp_mc_valid), .mc_wr(fp_mc_wr), .mc_len(fp_mc_len), .mc_addr(fp_mc_addr),
        .mc_data(fp_mc_data), .mc_abort(fp_mc_abort), .mc_ready(mc_ready), .mc_res(mc_res),
        .busy_out(fp_busy_out)
`ifdef MEM_ARB_PERF_EN
       ,.perf_grants(fp_perf_grants), .perf_aborts(fp_perf_aborts)
`endif
    );

    assign o_ready = use_fp ? fp_req_ready : req_ready;
    assign o_rdata = use_fp ? fp_req_rdata : req_rdata;
    assign o_valid = use_fp ? fp_mc_valid  : mc_valid;
    assign o_wr    = use_fp ? fp_mc_wr     : mc_wr;
    assign o_len   = use_fp ? fp_mc_len    : mc_len;
    assign o_addr  = use_fp ? fp_mc_addr   : mc_addr;
    assign o_data  = use_fp ? fp_mc_data   : mc_data;

    task automatic set_ch(input int ch, input logic wr, input logic [2:0] sz,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        req_wr[ch] = wr;
        req_size[ch*3 +: 3] = sz;
        req_addr[ch*AW +: AW] = addr;
        req_wdata[ch*DW +: DW] = wd;
    endtask

    task automatic push(input int ch, input logic [DW-1:0] rd, input int lat);
        exp_t e;
        e.ch = ch;
        e.wr = req_wr[ch];
        e.size = req_size[ch*3 +: 3];
        e.addr = req_addr[ch*AW +: AW];
        e.wdata = req_wdata[ch*DW +: DW];
        e.rdata = rd;
        e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0;
        rdy_in = 1'b1;
        flush_in = 1'b0;
        mc_ready = 1'b0;
        mc_res = '0;
        req_valid = '0;
        req_wr = '0;
        req_size = '0;
        req_addr = '0;
        req_wdata = '0;
        sb.delete();
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
    endtask

    // pops one expected access, acts as the memory controller for it, checks the completion
    task automatic serve(input string name);
        exp_t e;
        int w;
        logic [N-1:0] oh;
        e = sb.pop_front();
        oh = '0;
        oh[e.ch] = 1'b1;
        w = 0;
        while (!o_valid && w < 20) begin
            @(negedge clk_in);
            w++;
        end
        n_chk++;
        if (w !== e.lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles, want %0d", name, w, e.lat);
        end
        n_chk++;
        if ({o_wr, o_len, o_addr, o_data} !== {e.wr, e.size, e.addr, e.wdata}) begin
            n_fail++;
            $display("FAIL %s mc fields: got wr=%b len=%h addr=%h data=%h, want wr=%b len=%h addr=%h data=%h",
                     name, o_wr, o_len, o_addr, o_data, e.wr, e.size, e.addr, e.wdata);
        end
        n_chk++;
        if (o_ready !== '0) begin
            n_fail++;
            $display("FAIL %s early ready: got %b, want 00", name, o_ready);
        end
        mc_ready = 1'b1;
        mc_res = e.rdata;
        #1;
        n_chk++;
        if (o_ready !== oh) begin
            n_fail++;
            $display("FAIL %s req_ready: got %b, want %b", name, o_ready, oh);
        end
        n_chk++;
        if (o_rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL %s req_rdata: got %h, want %h", name, o_rdata, e.rdata);
        end
        @(posedge clk_in);
        #1;
        mc_ready = 1'b0;
        n_chk++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s mc_valid drop: got %b, want 0", name, o_valid);
        end
    endtask

    task automatic test_reset();
        use_fp = 1'b0;
        do_reset();
        rst_n_in = 1'b0;
        req_valid = 2'b11;
        repeat (2) @(negedge clk_in);
        n_chk++;
        if ({req_ready, req_rdata, mc_valid, mc_wr, mc_len, mc_addr, mc_data, mc_abort, busy_out} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs: got ready=%b rdata=%h valid=%b wr=%b len=%h addr=%h data=%h abort=%b busy=%b, want all 0",
                     req_ready, req_rdata, mc_valid, mc_wr, mc_len, mc_addr, mc_data, mc_abort, busy_out);
        end
        rst_n_in = 1'b1;
    endtask

    task automatic test_round_robin();
        use_fp = 1'b0;
        do_reset();
        set_ch(0, 1'b0, SZ_W, 32'h0000_0100, 32'h0);
        set_ch(1, 1'b1, SZ_H, 32'h0000_0200, 32'h0000_A5A5);
        req_valid = 2'b11;
        push(0, 32'h1111_0000, 1);
        push(1, 32'h2222_0000, 2);
        push(0, 32'h3333_0000, 2);
        push(1, 32'h4444_0000, 2);
        repeat (4) serve("rr");
        req_valid = '0;
    endtask

    task automatic test_fixed();
        use_fp = 1'b1;
        do_reset();
        set_ch(0, 1'b1, SZ_B, 32'h0000_0010, 32'h0000_00C3);
        set_ch(1, 1'b0, SZ_W, 32'h0000_0020, 32'h0);
        req_valid = 2'b11;
        push(0, 32'hF000_0001, 1);
        push(0, 32'hF000_0002, 2);
        push(0, 32'hF000_0003, 2);
        push(0, 32'hF000_0004, 2);
        repeat (4) serve("fixed");
        req_valid = '0;
        use_fp = 1'b0;
    endtask

    task automatic test_read_drop();
        use_fp = 1'b0;
        do_reset();
        set_ch(1, 1'b0, SZ_W, 32'h0000_1000, 32'h0);
        req_valid = 2'b10;
        @(negedge clk_in);
        req_valid = '0;
        push(1, 32'hDEAD_BEEF, 0);
        serve("read_drop");
        repeat (2) @(negedge clk_in);
        n_chk++;
        if ({mc_valid, busy_out} !== 2'b00) begin
            n_fail++;
            $display("FAIL read_drop idle: got valid=%b busy=%b, want 0 0", mc_valid, busy_out);
        end
    endtask

    task automatic test_flush();
        use_fp = 1'b0;
        do_reset();
        set_ch(0, 1'b0, SZ_W, 32'h0000_0300, 32'h0);
        set_ch(1, 1'b1, SZ_W, 32'h0000_0400, 32'h1234_5678);
        req_valid = 2'b11;
        @(negedge clk_in);
        n_chk++;
        if ({mc_valid, mc_addr} !== {1'b1, 32'h0000_0300}) begin
            n_fail++;
            $display("FAIL flush grant: got valid=%b addr=%h, want 1 00000300", mc_valid, mc_addr);
        end
        flush_in = 1'b1;
        mc_ready = 1'b1;
        mc_res = 32'hBAD0_BAD0;
        #1;
        n_chk++;
        if (req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL flush ready: got %b, want 00", req_ready);
        end
        @(posedge clk_in);
        #1;
        mc_ready = 1'b0;
        n_chk++;
        if ({mc_abort, mc_valid, busy_out} !== 3'b101) begin
            n_fail++;
            $display("FAIL flush abort: got abort=%b valid=%b busy=%b, want 1 0 1", mc_abort, mc_valid, busy_out);
        end
        // flush stays high: ch0 ineligible, ch1 (not flushable) must run to completion
        push(1, 32'h5555_AAAA, 3);
        serve("flush_ch1");
        n_chk++;
        if (mc_abort !== 1'b0) begin
            n_fail++;
            $display("FAIL flush abort width: got %b, want 0", mc_abort);
        end
        flush_in = 1'b0;
        push(0, 32'h0BAD_F00D, 2);
        serve("flush_ch0_retry");
        req_valid = '0;
    endtask

    task automatic test_rdy_and_async_reset();
        use_fp = 1'b0;
        do_reset();
        set_ch(0, 1'b0, SZ_W, 32'h0000_0500, 32'h0);
        req_valid = 2'b01;
        @(negedge clk_in);
        req_valid = '0;
        rdy_in = 1'b0;
        mc_ready = 1'b1;
        mc_res = 32'h0000_0077;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            n_chk++;
            if ({req_ready, mc_valid, busy_out} !== 4'b0011) begin
                n_fail++;
                $display("FAIL rdy_freeze %0d: got ready=%b valid=%b busy=%b, want 00 1 1",
                         i, req_ready, mc_valid, busy_out);
            end
        end
        rdy_in = 1'b1;
        #1;
        n_chk++;
        if ({req_ready, req_rdata} !== {2'b01, 32'h0000_0077}) begin
            n_fail++;
            $display("FAIL rdy_resume: got ready=%b rdata=%h, want 01 00000077", req_ready, req_rdata);
        end
        @(posedge clk_in);
        #1;
        mc_ready = 1'b0;
        n_chk++;
        if (mc_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rdy_done: mc_valid got %b, want 0", mc_valid);
        end
        req_valid = 2'b01;
        @(posedge clk_in);
        #1;
        n_chk++;
        if (mc_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset grant: mc_valid got %b, want 1", mc_valid);
        end
        #2;
        rst_n_in = 1'b0;
        #1;
        n_chk++;
        if ({mc_valid, busy_out, mc_addr} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got valid=%b busy=%b addr=%h, want 0 0 0", mc_valid, busy_out, mc_addr);
        end
        req_valid = '0;
    endtask

`ifdef MEM_ARB_PERF_EN
    task automatic test_perf();
        use_fp = 1'b0;
        do_reset();
        set_ch(0, 1'b0, SZ_W, 32'h0000_0600, 32'h0);
        set_ch(1, 1'b1, SZ_W, 32'h0000_0700, 32'h0000_0099);
        req_valid = 2'b01;
        push(0, 32'h1, 1);
        repeat (4) push(0, 32'h2, 2);
        repeat (5) serve("perf_ch0");
        req_valid = 2'b10;
        repeat (3) push(1, 32'h3, 2);
        repeat (3) serve("perf_ch1");
        req_valid = 2'b01;
        repeat (2) @(negedge clk_in);
        flush_in = 1'b1;
        @(posedge clk_in);
        #1;
        flush_in = 1'b0;
        req_valid = '0;
        repeat (2) @(negedge clk_in);
        n_chk++;
        if ({perf_grants, perf_aborts} !== {32'd3, 32'd5, 32'd1}) begin
            n_fail++;
            $display("FAIL perf counters: got grants=%h aborts=%0d, want 0000000300000005 1",
                     perf_grants, perf_aborts);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_fixed();
        test_read_drop();
        test_flush();
        test_rdy_and_async_reset();
`ifdef MEM_ARB_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
